// File: rtl/ps2_key_emitter.sv
// ASCII to PS/2 set-2 make/break emitter driving push-pull ps2_clk/ps2_data lines.
// Define PS2_EMIT_SHIFT_EN to support uppercase letters and shifted digit symbols.
module ps2_key_emitter #(
    parameter int HALF_CYC = 4000,
    parameter int GAP_CYC  = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ascii,
    input  logic       valid,
    output logic       ready,
    output logic       busy,
    output logic       err,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BIT_HI = 2'd1;
    localparam logic [1:0] BIT_LO = 2'd2;
    localparam logic [1:0] GAP    = 2'd3;

    localparam logic [15:0] HALF_LAST = 16'(HALF_CYC - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);

    typedef struct packed {
        logic       ok;
        logic       shift;
        logic [7:0] code;
    } key_t;

    function automatic logic [7:0] letter_code(input logic [4:0] idx);
        case (idx)
            5'd0:  letter_code = 8'h1C;  5'd1:  letter_code = 8'h32;
            5'd2:  letter_code = 8'h21;  5'd3:  letter_code = 8'h23;
            5'd4:  letter_code = 8'h24;  5'd5:  letter_code = 8'h2B;
            5'd6:  letter_code = 8'h34;  5'd7:  letter_code = 8'h33;
            5'd8:  letter_code = 8'h43;  5'd9:  letter_code = 8'h3B;
            5'd10: letter_code = 8'h42;  5'd11: letter_code = 8'h4B;
            5'd12: letter_code = 8'h3A;  5'd13: letter_code = 8'h31;
            5'd14: letter_code = 8'h44;  5'd15: letter_code = 8'h4D;
            5'd16: letter_code = 8'h15;  5'd17: letter_code = 8'h2D;
            5'd18: letter_code = 8'h1B;  5'd19: letter_code = 8'h2C;
            5'd20: letter_code = 8'h3C;  5'd21: letter_code = 8'h2A;
            5'd22: letter_code = 8'h1D;  5'd23: letter_code = 8'h22;
            5'd24: letter_code = 8'h35;  5'd25: letter_code = 8'h1A;
            default: letter_code = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] digit_code(input logic [3:0] d);
        case (d)
            4'd0: digit_code = 8'h45;  4'd1: digit_code = 8'h16;
            4'd2: digit_code = 8'h1E;  4'd3: digit_code = 8'h26;
            4'd4: digit_code = 8'h25;  4'd5: digit_code = 8'h2E;
            4'd6: digit_code = 8'h36;  4'd7: digit_code = 8'h3D;
            4'd8: digit_code = 8'h3E;  4'd9: digit_code = 8'h46;
            default: digit_code = 8'h00;
        endcase
    endfunction

    logic [1:0]  state;
    logic [15:0] cnt;
    logic [3:0]  bit_idx;
    logic [2:0]  byte_idx;
    logic [7:0]  code_q;
    logic        shift_q;
    logic        err_q;
    key_t        key;
    logic [7:0]  lo_off, dig_off;
    logic [7:0]  cur_byte;
    logic [10:0] frame;
    logic [2:0]  last_byte;

    assign lo_off  = ascii - 8'h61;
    assign dig_off = ascii - 8'h30;

    always_comb begin
        key = '0;
        if (ascii >= 8'h61 && ascii <= 8'h7A) begin
            key.ok   = 1'b1;
            key.code = letter_code(lo_off[4:0]);
        end else if (ascii >= 8'h30 && ascii <= 8'h39) begin
            key.ok   = 1'b1;
            key.code = digit_code(dig_off[3:0]);
        end
`ifdef PS2_EMIT_SHIFT_EN
        else if (ascii >= 8'h41 && ascii <= 8'h5A) begin
            key.ok    = 1'b1;
            key.shift = 1'b1;
            key.code  = letter_code(ascii[4:0] - 5'd1);
        end else begin
            // Shifted symbols share the key of the digit printed beneath them.
            key.shift = 1'b1;
            key.ok    = 1'b1;
            case (ascii)
                8'h29:   key.code = digit_code(4'd0);
                8'h21:   key.code = digit_code(4'd1);
                8'h40:   key.code = digit_code(4'd2);
                8'h23:   key.code = digit_code(4'd3);
                8'h24:   key.code = digit_code(4'd4);
                8'h25:   key.code = digit_code(4'd5);
                8'h5E:   key.code = digit_code(4'd6);
                8'h26:   key.code = digit_code(4'd7);
                8'h2A:   key.code = digit_code(4'd8);
                8'h28:   key.code = digit_code(4'd9);
                default: key = '0;
            endcase
        end
`endif
    end

    // Unshifted: code F0 code. Shifted: 12 code F0 code F0 12.
    always_comb begin
        cur_byte = code_q;
        if (shift_q) begin
            case (byte_idx)
                3'd0, 3'd5: cur_byte = 8'h12;
                3'd2, 3'd4: cur_byte = 8'hF0;
                default:    cur_byte = code_q;
            endcase
        end else if (byte_idx == 3'd1) begin
            cur_byte = 8'hF0;
        end
    end

    assign last_byte = shift_q ? 3'd5 : 3'd2;
    assign frame     = {1'b1, ~^cur_byte, cur_byte, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            code_q   <= '0;
            shift_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: if (valid) begin
                    if (key.ok) begin
                        state    <= BIT_HI;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        code_q   <= key.code;
                        shift_q  <= key.shift;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                BIT_HI: if (cnt == HALF_LAST) begin
                    cnt   <= '0;
                    state <= BIT_LO;
                end else begin
                    cnt <= cnt + 16'd1;
                end
                BIT_LO: if (cnt == HALF_LAST) begin
                    cnt <= '0;
                    if (bit_idx == 4'd10) begin
                        bit_idx <= '0;
                        state   <= GAP;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                        state   <= BIT_HI;
                    end
                end else begin
                    cnt <= cnt + 16'd1;
                end
                default: if (cnt == GAP_LAST) begin
                    cnt <= '0;
                    if (byte_idx == last_byte) begin
                        state <= IDLE;
                    end else begin
                        byte_idx <= byte_idx + 3'd1;
                        state    <= BIT_HI;
                    end
                end else begin
                    cnt <= cnt + 16'd1;
                end
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign ready    = ~busy;
    assign err      = err_q;
    assign ps2_clk  = (state != BIT_LO);
    assign ps2_data = (state == BIT_HI || state == BIT_LO) ? frame[bit_idx] : 1'b1;

endmodule
